// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a hold counter
// that forces rotation once the owner has held the grant MAX_HOLD cycles while others wait.
`timescale 1ns/1ps

module rr_ring_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = $clog2(MAX_HOLD + 1),
   parameter int ID_W     = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N-1:0]      req,
   output logic [N-1:0]      grant,
   output logic              grant_valid,
   output logic [ID_W-1:0]   grant_id,
   output logic [N-1:0]      ptr,
   output logic [HOLD_W-1:0] hold_cnt,
   output logic              arb_state
);

   // Interface contract: grant_valid is high exactly while one grant bit is set;
   // a requester owns the resource for every cycle its grant bit is high, and gives
   // it back by dropping req (observed at the next rising edge).

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   state_t              state_q, state_d;
   logic [N-1:0]        grant_q, grant_d;
   logic [N-1:0]        ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;

   logic [N-1:0]        others;
   logic [N-1:0]        ptr_next;
   logic                release_grant;
   logic                timeout;

   // First set bit of v, scanning upward from the bit set in p, wrapping at N-1.
   function automatic logic [N-1:0] sel(input logic [N-1:0] v, input logic [N-1:0] p);
      logic [N-1:0] r;
      logic         found;
      int           base;
      int           idx;
      r     = '0;
      found = 1'b0;
      base  = 0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         if (p[i]) base = i;
      end
      for (int k = 0; k < N; k++) begin
         idx = (base + k >= N) ? (base + k - N) : (base + k);
         if (!found && v[idx]) begin
            r[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rot(input logic [N-1:0] g);
      return {g[N-2:0], g[N-1]};
   endfunction

   assign others        = req & ~grant_q;
   assign ptr_next      = rot(grant_q);
   assign release_grant = ~|(req & grant_q);
   assign timeout       = (hold_q == HOLD_MAX) && (|others);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= {{(N-1){1'b0}}, 1'b1};
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = sel(req, ptr_q);
               hold_d  = HOLD_ONE;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Release and timeout together are one end-of-grant: pointer moves once.
            if (release_grant || timeout) begin
               ptr_d = ptr_next;
               if (|others) begin
                  grant_d = sel(others, ptr_next);
                  hold_d  = HOLD_ONE;
               end else begin
                  grant_d = '0;
                  hold_d  = '0;
                  state_d = IDLE;
               end
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) grant_id = ID_W'(i);
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign ptr         = ptr_q;
   assign hold_cnt    = hold_q;
   assign arb_state   = state_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter: each stimulus step queues its hand-computed
// post-edge outputs; a monitor pops and compares one entry per clock edge.
`timescale 1ns/1ps

module tb_rr_ring_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int HOLD_W   = 4;
   localparam int ID_W     = 2;
   localparam int W        = N + 1 + ID_W + N + HOLD_W;

   logic              clk;
   logic              reset_n;
   logic [N-1:0]      req;
   logic [N-1:0]      grant;
   logic              grant_valid;
   logic [ID_W-1:0]   grant_id;
   logic [N-1:0]      ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic              arb_state;

   logic [W-1:0] exp_q[$];
   string        lbl_q[$];
   int           checks;
   int           passed;

   rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_id   (grant_id),
      .ptr        (ptr),
      .hold_cnt   (hold_cnt),
      .arb_state  (arb_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic step(input string lbl, input logic [N-1:0] r, input logic [N-1:0] g,
                       input logic [N-1:0] p, input int h);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < N; i++) if (g[i]) id = ID_W'(i);
      @(negedge clk);
      req = r;
      exp_q.push_back({g, |g, id, p, HOLD_W'(h)});
      lbl_q.push_back(lbl);
   endtask

   task automatic check_reset(input string lbl);
      logic [W:0] act;
      logic [W:0] want;
      act  = {grant, grant_valid, grant_id, ptr, hold_cnt, arb_state};
      want = {4'b0000, 1'b0, 2'd0, 4'b0001, 4'd0, 1'b0};
      checks++;
      if (act === want) passed++;
      else $display("FAIL %s: got grant=%b gv=%b id=%0d ptr=%b hold=%0d st=%b, want grant=0000 gv=0 id=0 ptr=0001 hold=0 st=0",
                    lbl, grant, grant_valid, grant_id, ptr, hold_cnt, arb_state);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req     = '0;
      reset_n = 1'b0;
      @(negedge clk);
      check_reset("reset_between");
      reset_n = 1'b1;
   endtask

   // scoreboard monitor
   always begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        l;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         l = lbl_q.pop_front();
         a = {grant, grant_valid, grant_id, ptr, hold_cnt};
         checks++;
         if (a === e) passed++;
         else $display("FAIL %s: got grant=%b gv=%b id=%0d ptr=%b hold=%0d, want grant=%b gv=%b id=%0d ptr=%b hold=%0d",
                       l, grant, grant_valid, grant_id, ptr, hold_cnt,
                       e[W-1 -: N], e[W-N-1], e[W-N-2 -: ID_W], e[N+HOLD_W-1 -: N], e[HOLD_W-1:0]);
      end
   end

   initial begin
      checks  = 0;
      passed  = 0;
      reset_n = 1'b0;
      req     = '0;
      repeat (2) @(negedge clk);
      check_reset("reset_init");
      reset_n = 1'b1;

      // single requester, 3-cycle grant, then release
      step("single1", 4'b0100, 4'b0100, 4'b0001, 1);
      step("single2", 4'b0100, 4'b0100, 4'b0001, 2);
      step("single3", 4'b0100, 4'b0100, 4'b0001, 3);
      step("single_rel", 4'b0000, 4'b0000, 4'b1000, 0);

      // wrap-around scan from bit 3 to bit 0
      step("wrap_grant", 4'b0101, 4'b0001, 4'b1000, 1);
      step("wrap_rel", 4'b0000, 4'b0000, 4'b0010, 0);
      step("idle_hold", 4'b0000, 4'b0000, 4'b0010, 0);

      // timeout alternation with req=0011
      do_reset();
      for (int k = 1; k <= 8; k++) step("tmo_a", 4'b0011, 4'b0001, 4'b0001, k);
      for (int k = 1; k <= 8; k++) step("tmo_b", 4'b0011, 4'b0010, 4'b0010, k);
      for (int k = 1; k <= 8; k++) step("tmo_c", 4'b0011, 4'b0001, 4'b0100, k);
      step("tmo_d", 4'b0011, 4'b0010, 4'b0010, 1);

      // asynchronous reset between edges while requester 1 owns the grant
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      req     = '0;
      #1;
      check_reset("reset_async");
      @(negedge clk);
      reset_n = 1'b1;
      step("post_reset_idle", 4'b0000, 4'b0000, 4'b0001, 0);

      // no contention: hold saturates, pointer unchanged
      for (int k = 1; k <= 20; k++)
         step("solo", 4'b0001, 4'b0001, 4'b0001, (k > MAX_HOLD) ? MAX_HOLD : k);
      step("solo_rel", 4'b0000, 4'b0000, 4'b0010, 0);

      // full contention, each owner drops for one cycle after 2 grant cycles
      do_reset();
      step("full1", 4'b1111, 4'b0001, 4'b0001, 1);
      step("full2", 4'b1111, 4'b0001, 4'b0001, 2);
      step("full3", 4'b1110, 4'b0010, 4'b0010, 1);
      step("full4", 4'b1111, 4'b0010, 4'b0010, 2);
      step("full5", 4'b1101, 4'b0100, 4'b0100, 1);
      step("full6", 4'b1111, 4'b0100, 4'b0100, 2);
      step("full7", 4'b1011, 4'b1000, 4'b1000, 1);
      step("full8", 4'b1111, 4'b1000, 4'b1000, 2);
      step("full9", 4'b0111, 4'b0001, 4'b0001, 1);
      step("full10", 4'b1111, 4'b0001, 4'b0001, 2);

      // final report
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
